uart_rx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx_cfg.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, sampling helper,
// and the constants that shape divisor and data-length handling.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_START      = 3'd1,
        RX_DATA       = 3'd2,
        RX_PARITY     = 3'd3,
        RX_STOP       = 3'd4,
        RX_BREAK_WAIT = 3'd5
    } rx_state_e;

    // Smallest usable divisor; three distinct sample points need at least 8 clocks per bit.
    localparam int MIN_DIV = 8;

    // i_data_len is "data bits minus 5"; code 3 means 8 bits and anything above clamps.
    localparam int         DATA_LEN_BASE = 5;
    localparam logic [2:0] LEN_CODE_MAX  = 3'd3;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for asynchronous single-bit inputs. Resets to 1 so an
// idle-high line never produces a spurious falling edge out of reset.
module uart_sync #(
    parameter int Stages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] chain;

    // Shift the raw input through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[Stages-2:0], d};
        end
    end

    assign q = chain[Stages-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with per-frame latched configuration, majority-of-three bit
// sampling, per-frame error reporting and a single-entry valid/ready output.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | waiting for a synced 1->0 edge on the line
//   START       | validating the start bit; majority 1 is a false start
//   DATA        | shifting in data bits, LSB first
//   PARITY      | checking the parity bit against the running XOR
//   STOP        | sampling stop bit(s), then one commit cycle
//   BREAK_WAIT  | break seen; hold until the line returns high
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int MaxDataLength = 8,
    parameter int DivWidth      = 16,
    parameter int SyncStages    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    input  logic [DivWidth-1:0]      i_div,
    input  logic [2:0]               i_data_len,
    input  logic                     i_parity_en,
    input  logic                     i_parity_odd,
    input  logic                     i_two_stop,
    output logic [MaxDataLength-1:0] o_rx_data,
    output logic                     o_rx_valid,
    input  logic                     i_rx_ready,
    output logic                     o_parity_err,
    output logic                     o_frame_err,
    output logic                     o_break,
    output logic                     o_overrun,
    output logic                     o_busy
);

    localparam logic [2:0] ST_IDLE       = 3'(RX_IDLE);
    localparam logic [2:0] ST_START      = 3'(RX_START);
    localparam logic [2:0] ST_DATA       = 3'(RX_DATA);
    localparam logic [2:0] ST_PARITY     = 3'(RX_PARITY);
    localparam logic [2:0] ST_STOP       = 3'(RX_STOP);
    localparam logic [2:0] ST_BREAK_WAIT = 3'(RX_BREAK_WAIT);

    logic                     rx_s;
    logic                     rx_prev;
    logic [2:0]               state;
    logic [DivWidth-1:0]      cnt;
    logic [DivWidth-1:0]      cnt_next;
    logic [DivWidth-1:0]      div_q;
    logic [DivWidth-1:0]      div_in;
    logic [3:0]               len_q;
    logic [3:0]               len_in;
    logic                     par_en_q;
    logic                     par_odd_q;
    logic                     two_stop_q;
    logic [2:0]               bit_idx;
    logic                     stop_idx;
    logic [1:0]               samp;
    logic [MaxDataLength-1:0] data_sh;
    logic                     par_acc;
    logic                     par_err_q;
    logic                     all_zero;
    logic                     stop1_zero;
    logic                     fin_ferr;
    logic                     fin_brk;
    logic                     commit_q;

    logic [DivWidth-1:0]      pt_1;
    logic [DivWidth-1:0]      pt_2;
    logic [DivWidth-1:0]      pt_3;
    logic                     at_s3;
    logic                     at_end;
    logic                     maj;
    logic                     start_edge;

    uart_sync #(.Stages(SyncStages)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d       (i_rx),
        .q       (rx_s)
    );

    // Config values as they would be latched at a start edge (clamped).
    always_comb begin
        div_in = (i_div < DivWidth'(MIN_DIV)) ? DivWidth'(MIN_DIV) : i_div;
        if (i_data_len > LEN_CODE_MAX) begin
            len_in = 4'(MaxDataLength);
        end else begin
            len_in = 4'(i_data_len) + 4'(DATA_LEN_BASE);
        end
        if (len_in > 4'(MaxDataLength)) begin
            len_in = 4'(MaxDataLength);
        end
    end

    // Sample points and bit-timing strobes derived from the latched divisor.
    always_comb begin
        pt_2       = div_q >> 1;
        pt_1       = pt_2 - (div_q >> 3);
        pt_3       = pt_2 + (div_q >> 3);
        at_s3      = (cnt == pt_3);
        at_end     = (cnt == div_q - DivWidth'(1));
        cnt_next   = at_end ? '0 : cnt + DivWidth'(1);
        maj        = majority3(samp[0], samp[1], rx_s);
        start_edge = rx_prev & ~rx_s;
    end

    // Edge-detect history and the first two samples of each bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_prev <= 1'b1;
            samp    <= '0;
        end else begin
            rx_prev <= rx_s;
            if (cnt == pt_1) samp[0] <= rx_s;
            if (cnt == pt_2) samp[1] <= rx_s;
        end
    end

    // Receive FSM: bit timing, shifting, parity/stop evaluation, commit request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            div_q      <= DivWidth'(MIN_DIV);
            len_q      <= 4'(MaxDataLength);
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            data_sh    <= '0;
            par_acc    <= 1'b0;
            par_err_q  <= 1'b0;
            all_zero   <= 1'b1;
            stop1_zero <= 1'b0;
            fin_ferr   <= 1'b0;
            fin_brk    <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state      <= ST_START;
                        cnt        <= '0;
                        div_q      <= div_in;
                        len_q      <= len_in;
                        par_en_q   <= i_parity_en;
                        par_odd_q  <= i_parity_odd;
                        two_stop_q <= i_two_stop;
                        bit_idx    <= '0;
                        stop_idx   <= 1'b0;
                        data_sh    <= '0;
                        par_acc    <= 1'b0;
                        par_err_q  <= 1'b0;
                        all_zero   <= 1'b1;
                        stop1_zero <= 1'b0;
                    end
                end
                ST_START: begin
                    cnt <= cnt_next;
                    if (at_s3 && maj) begin
                        state <= ST_IDLE;
                    end else if (at_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    cnt <= cnt_next;
                    if (at_s3) begin
                        data_sh[bit_idx] <= maj;
                        par_acc          <= par_acc ^ maj;
                        if (maj) all_zero <= 1'b0;
                    end
                    if (at_end) begin
                        if ({1'b0, bit_idx} == len_q - 4'd1) begin
                            bit_idx <= '0;
                            state   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    cnt <= cnt_next;
                    if (at_s3) begin
                        par_err_q <= maj ^ par_acc ^ par_odd_q;
                        if (maj) all_zero <= 1'b0;
                    end
                    if (at_end) state <= ST_STOP;
                end
                ST_STOP: begin
                    cnt <= cnt_next;
                    if (commit_q) begin
                        // Leave right after the commit instead of waiting for the bit end.
                        state <= fin_brk ? ST_BREAK_WAIT : ST_IDLE;
                    end else if (at_s3) begin
                        if (two_stop_q && !stop_idx) begin
                            stop1_zero <= ~maj;
                        end else begin
                            fin_ferr <= ~maj | (stop_idx & stop1_zero);
                            fin_brk  <= all_zero & (stop_idx ? stop1_zero : ~maj);
                            commit_q <= 1'b1;
                        end
                    end else if (at_end && two_stop_q && !stop_idx) begin
                        stop_idx <= 1'b1;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register: load on commit if free or being drained, else flag overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (commit_q) begin
                if (!o_rx_valid || i_rx_ready) begin
                    o_rx_data    <= data_sh;
                    o_parity_err <= par_err_q;
                    o_frame_err  <= fin_ferr | fin_brk;
                    o_break      <= fin_brk;
                    o_rx_valid   <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed framing/error scenarios followed by
// randomized frames, all checked against a frame-level reference model.
module tb_uart_rx_cfg;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_rx = 1'b1;
    logic [15:0] i_div = 16'd16;
    logic [2:0]  i_data_len = 3'd3;
    logic        i_parity_en = 1'b0;
    logic        i_parity_odd = 1'b0;
    logic        i_two_stop = 1'b0;
    logic        i_rx_ready = 1'b1;
    logic [7:0]  o_rx_data;
    logic        o_rx_valid;
    logic        o_parity_err;
    logic        o_frame_err;
    logic        o_break;
    logic        o_overrun;
    logic        o_busy;

    int vectors = 0;
    int miscompares = 0;
    logic [10:0] got_q[$];
    int ovr_cnt = 0;
    int valid_cycles = 0;

    uart_rx_cfg #(.MaxDataLength(8), .DivWidth(16), .SyncStages(2)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rx         (i_rx),
        .i_div        (i_div),
        .i_data_len   (i_data_len),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_two_stop   (i_two_stop),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .i_rx_ready   (i_rx_ready),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_break      (o_break),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Record accepted frames and output activity, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_rx_valid && i_rx_ready) got_q.push_back({o_break, o_frame_err, o_parity_err, o_rx_data});
            if (o_overrun) ovr_cnt++;
            if (o_rx_valid) valid_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: what the receiver must report for a frame sent with these bits.
    function automatic logic [10:0] model(input logic [7:0] data, input int nbits, input logic pen,
                                          input logic podd, input logic pbit, input logic two,
                                          input logic s1, input logic s2);
        logic [7:0] d;
        logic perr, brk, ferr, want_p;
        d      = data & 8'((32'd1 << nbits) - 1);
        want_p = ($countones(d) % 2 == 1) ^ podd;
        perr   = pen && (pbit != want_p);
        brk    = (d == 8'd0) && (!pen || !pbit) && !s1;
        ferr   = !s1 || (two && !s2) || brk;
        return {brk, ferr, perr, d};
    endfunction

    function automatic int eff_div(input logic [15:0] div);
        return (div < 16'd8) ? 8 : int'(div);
    endfunction

    function automatic int bits_of(input logic [2:0] dl);
        return (dl > 3'd3) ? 8 : int'(dl) + 5;
    endfunction

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                              input logic pbit, input logic two, input logic s1, input logic s2,
                              input int t, input bit scramble);
        i_rx = 1'b0;
        tick(t / 2);
        if (scramble) begin
            i_div        = 16'($urandom);
            i_data_len   = 3'($urandom);
            i_parity_en  = 1'($urandom);
            i_parity_odd = 1'($urandom);
            i_two_stop   = 1'($urandom);
        end
        tick(t - t / 2);
        for (int i = 0; i < nbits; i++) begin
            i_rx = data[i];
            tick(t);
        end
        if (pen) begin
            i_rx = pbit;
            tick(t);
        end
        i_rx = s1;
        tick(t);
        if (two) begin
            i_rx = s2;
            tick(t);
        end
        i_rx = 1'b1;
        tick(2 * t);
    endtask

    task automatic check_frame(input string tag, input logic [10:0] exp);
        check({tag, " count"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() != 0) check(tag, 32'(got_q.pop_front()), 32'(exp));
        got_q.delete();
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [2:0] dl, input logic pen,
                           input logic podd, input logic two);
        i_div        = div;
        i_data_len   = dl;
        i_parity_en  = pen;
        i_parity_odd = podd;
        i_two_stop   = two;
    endtask

    initial begin
        int vc0;
        int ov0;
        logic [15:0] r_div;
        logic [2:0]  r_dl;
        logic        r_pen, r_podd, r_two, r_pbit, r_s1, r_s2;
        logic [7:0]  r_data;
        int          t;

        // Reset state
        tick(3);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst valid", 32'(o_rx_valid), 32'd0);
        check("rst data", 32'(o_rx_data), 32'd0);
        check("rst flags", 32'({o_parity_err, o_frame_err, o_break, o_overrun}), 32'd0);
        i_rst_n = 1'b1;
        tick(4);

        // 8N1 0xA5, ready high: one valid cycle, clean flags
        set_cfg(16'd16, 3'd3, 1'b0, 1'b0, 1'b0);
        vc0 = valid_cycles;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        check_frame("8n1 a5", model(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        check("8n1 valid cycles", 32'(valid_cycles - vc0), 32'd1);

        // 7E1 0x35 with a wrong parity bit
        set_cfg(16'd16, 3'd2, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        check_frame("7e1 perr", model(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));

        // 8N2 with second stop low, then a clean frame
        set_cfg(16'd16, 3'd3, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0);
        check_frame("8n2 ferr", model(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16, 1'b0);
        check_frame("8n2 clean", model(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));

        // Break: line low for 12 bit times
        set_cfg(16'd16, 3'd3, 1'b0, 1'b0, 1'b0);
        i_rx = 1'b0;
        tick(12 * 16);
        i_rx = 1'b1;
        tick(3 * 16);
        check_frame("break", 11'b110_0000_0000);
        check("break idle", 32'(o_busy), 32'd0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        check_frame("after break", model(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

        // Overrun: ready low, second frame dropped
        i_rx_ready = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        check("ovr held valid", 32'(o_rx_valid), 32'd1);
        ov0 = ovr_cnt;
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        check("ovr pulses", 32'(ovr_cnt - ov0), 32'd1);
        check("ovr held data", 32'(o_rx_data), 32'h11);
        i_rx_ready = 1'b1;
        tick(1);
        check("ovr valid cleared", 32'(o_rx_valid), 32'd0);
        check_frame("ovr kept 11", 11'h011);

        // False start: div/4 glitch
        i_rx = 1'b0;
        tick(4);
        i_rx = 1'b1;
        tick(48);
        check("glitch busy", 32'(o_busy), 32'd0);
        check("glitch frames", 32'(got_q.size()), 32'd0);

        // Reset in the middle of DATA
        i_rx = 1'b0;
        tick(16);
        i_rx = 1'b1;
        tick(16);
        i_rx = 1'b0;
        tick(8);
        i_rst_n = 1'b0;
        tick(1);
        check("midrst outputs", 32'({o_busy, o_rx_valid, o_parity_err, o_frame_err, o_break, o_overrun}), 32'd0);
        check("midrst data", 32'(o_rx_data), 32'd0);
        i_rx = 1'b1;
        tick(2);
        i_rst_n = 1'b1;
        tick(20);
        check("midrst frames", 32'(got_q.size()), 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        check_frame("after midrst", model(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

        // Randomized frames with config scrambled mid-frame
        for (int n = 0; n < 24; n++) begin
            r_div  = 16'($urandom_range(4, 24));
            r_dl   = 3'($urandom_range(0, 7));
            r_pen  = 1'($urandom);
            r_podd = 1'($urandom);
            r_two  = 1'($urandom);
            r_data = 8'($urandom);
            r_pbit = 1'($urandom);
            r_s1   = ($urandom_range(0, 5) != 0);
            r_s2   = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 7) == 0) begin
                r_data = 8'd0;
                r_pbit = 1'b0;
                r_s1   = 1'b0;
            end
            t = eff_div(r_div);
            set_cfg(r_div, r_dl, r_pen, r_podd, r_two);
            send_frame(r_data, bits_of(r_dl), r_pen, r_pbit, r_two, r_s1, r_s2, t, 1'b1);
            check_frame($sformatf("rand %0d", n),
                        model(r_data, bits_of(r_dl), r_pen, r_podd, r_pbit, r_two, r_s1, r_s2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
